sha_job_scheduler: RTL and testbench

SHA_JOB_SCHEDULER -- requirements
Module: sha_job_scheduler

---
 rtl/sha_sched_pkg.sv | 20 ++
 rtl/sha_job_fifo.sv | 51 +++++
 rtl/sha_job_scheduler.sv | 125 ++++++++++++
 tb/tb_sha_job_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_sched_pkg.sv
// Shared types and parameter defaults for the SHA job scheduler and its job FIFO.
package sha_sched_pkg;

  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ERROR
  } sched_state_t;

  typedef struct packed {
    logic [15:0] msg_addr;
    logic [15:0] out_addr;
  } job_t;

endpackage

// File: rtl/sha_job_fifo.sv
// Synchronous job FIFO: read/write pointers plus an occupancy count.
// Full is judged on the pre-pop occupancy, so ready never waits on a same-cycle pop.
module sha_job_fifo
  import sha_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  job_t din,
  input  logic pop,
  output job_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  job_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sha_job_scheduler.sv
// Queues hash jobs and sequences them one at a time onto an external SHA core.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | waiting for a queued job and an idle core
//   S_ISSUE     | core_start high for this single cycle, timer cleared
//   S_WAIT_BUSY | waiting for the core to drop core_done
//   S_WAIT_DONE | waiting for the core to raise core_done again
//   S_ERROR     | core exceeded TIMEOUT; held until clr_err
module sha_job_scheduler
  import sha_sched_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_msg_addr,
  input  logic [15:0] job_out_addr,
  output logic        core_start,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_done,
  output logic        cmp_valid,
  output logic [15:0] cmp_out_addr,
  output logic [15:0] jobs_done,
  output logic        busy,
  output logic        err,
  input  logic        clr_err
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT);

  sched_state_t  state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  job_t          job_in;
  job_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign job_in.msg_addr = job_msg_addr;
  assign job_in.out_addr = job_out_addr;
  assign job_ready       = !fifo_full;
  assign busy            = (state != S_IDLE) || !fifo_empty;
  assign timer_inc       = timer + 1'b1;
  // Holding off while cmp_valid is up guarantees a full IDLE cycle between jobs.
  assign pop = (state == S_IDLE) && !fifo_empty && core_done && !cmp_valid;

  sha_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (job_valid),
    .din   (job_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      timer             <= '0;
      core_start        <= 1'b0;
      core_message_addr <= '0;
      core_output_addr  <= '0;
      cmp_valid         <= 1'b0;
      cmp_out_addr      <= '0;
      jobs_done         <= '0;
      err               <= 1'b0;
    end else begin
      core_start <= 1'b0;
      cmp_valid  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            state             <= S_ISSUE;
            core_start        <= 1'b1;
            core_message_addr <= head.msg_addr;
            core_output_addr  <= head.out_addr;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT_BUSY;
        end
        // Timeout wins over a same-cycle core_done change.
        S_WAIT_BUSY: begin
          timer <= timer_inc;
          if (timer_inc == TLIMIT) begin
            state <= S_ERROR;
            err   <= 1'b1;
          end else if (!core_done) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          timer <= timer_inc;
          if (timer_inc == TLIMIT) begin
            state <= S_ERROR;
            err   <= 1'b1;
          end else if (core_done) begin
            state        <= S_IDLE;
            cmp_valid    <= 1'b1;
            cmp_out_addr <= core_output_addr;
            jobs_done    <= jobs_done + 1'b1;
          end
        end
        S_ERROR: begin
          if (clr_err) begin
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Two schedulers (TIMEOUT 1024 and 50) share stimulus; a queue-based job model
// predicts every output each cycle, plus directed literal checks per scenario.
module tb_sha_job_scheduler;
  import sha_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO0   = 1024;
  localparam int TO1   = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              job_valid = 1'b0;
  logic              clr_err = 1'b0;
  logic [15:0]       job_msg_addr = '0;
  logic [15:0]       job_out_addr = '0;
  logic [1:0]        core_done = 2'b11;
  logic [1:0]        job_ready, core_start, cmp_valid, busy, err;
  logic [1:0][15:0]  cma, coa, cout, jobs_done;

  int checks = 0;
  int errors = 0;

  // core model controls
  int cdly = 1, cblen = 200;
  bit cnever = 0, crand = 0;
  int chold [2];
  int clow [2];

  // behavioural job model
  typedef enum int {M_IDLE, M_START, M_RUN, M_ERR} mph_t;
  job_t        mq [2][$];
  mph_t        mph [2];
  int          mwait [2];
  bit          mlow [2];
  bit          mcmp [2];
  bit          merr [2];
  logic [15:0] mjobs [2];
  logic [15:0] mcmpa [2];
  logic [15:0] mmsg [2];
  logic [15:0] mout [2];

  // inputs captured before each edge
  bit   started = 0;
  bit   c_rst, c_clr;
  bit   c_push [2];
  bit   c_done [2];
  job_t c_din;

  logic [15:0] cmp_log [2][$];
  int          starts [2];

  always #5 clk = ~clk;

  sha_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TO0)) dut0 (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready[0]),
    .job_msg_addr(job_msg_addr), .job_out_addr(job_out_addr),
    .core_start(core_start[0]), .core_message_addr(cma[0]), .core_output_addr(coa[0]),
    .core_done(core_done[0]), .cmp_valid(cmp_valid[0]), .cmp_out_addr(cout[0]),
    .jobs_done(jobs_done[0]), .busy(busy[0]), .err(err[0]), .clr_err(clr_err));

  sha_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TO1)) dut1 (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready[1]),
    .job_msg_addr(job_msg_addr), .job_out_addr(job_out_addr),
    .core_start(core_start[1]), .core_message_addr(cma[1]), .core_output_addr(coa[1]),
    .core_done(core_done[1]), .cmp_valid(cmp_valid[1]), .cmp_out_addr(cout[1]),
    .jobs_done(jobs_done[1]), .busy(busy[1]), .err(err[1]), .clr_err(clr_err));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  function automatic int tlim(input int i);
    return (i == 0) ? TO0 : TO1;
  endfunction

  task automatic model_step(input int i);
    job_t j;
    bit   cmp_now;
    if (c_rst) begin
      mq[i].delete();
      mph[i] = M_IDLE; mwait[i] = 0; mlow[i] = 0; mcmp[i] = 0; merr[i] = 0;
      mjobs[i] = '0; mcmpa[i] = '0; mmsg[i] = '0; mout[i] = '0;
    end else begin
      cmp_now = 0;
      case (mph[i])
        M_IDLE: if (mq[i].size() > 0 && c_done[i] && !mcmp[i]) begin
          j = mq[i].pop_front();
          mmsg[i] = j.msg_addr;
          mout[i] = j.out_addr;
          mph[i]  = M_START;
        end
        M_START: begin
          mph[i] = M_RUN; mwait[i] = 0; mlow[i] = 0;
        end
        M_RUN: begin
          mwait[i]++;
          if (mwait[i] == tlim(i)) begin
            mph[i] = M_ERR; merr[i] = 1;
          end else if (!mlow[i]) begin
            if (!c_done[i]) mlow[i] = 1;
          end else if (c_done[i]) begin
            mph[i] = M_IDLE; cmp_now = 1; mcmpa[i] = mout[i]; mjobs[i] = mjobs[i] + 16'd1;
          end
        end
        M_ERR: if (c_clr) begin
          merr[i] = 0; mph[i] = M_IDLE;
        end
        default: ;
      endcase
      if (c_push[i]) mq[i].push_back(c_din);
      mcmp[i] = cmp_now;
    end
  endtask

  task automatic compare(input int i);
    chk($sformatf("job_ready%0d", i), job_ready[i], mq[i].size() < DEPTH);
    chk($sformatf("core_start%0d", i), core_start[i], mph[i] == M_START);
    chk($sformatf("cmp_valid%0d", i), cmp_valid[i], mcmp[i]);
    chk($sformatf("cmp_out_addr%0d", i), cout[i], mcmpa[i]);
    chk($sformatf("core_message_addr%0d", i), cma[i], mmsg[i]);
    chk($sformatf("core_output_addr%0d", i), coa[i], mout[i]);
    chk($sformatf("jobs_done%0d", i), jobs_done[i], mjobs[i]);
    chk($sformatf("err%0d", i), err[i], merr[i]);
    chk($sformatf("busy%0d", i), busy[i], (mph[i] != M_IDLE) || (mq[i].size() != 0));
    if (cmp_valid[i]) cmp_log[i].push_back(cout[i]);
    if (core_start[i]) starts[i]++;
  endtask

  // compare process: model advances over the edge just passed, then checks outputs
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (started) begin
          model_step(i);
          compare(i);
        end
      end
      c_rst = reset;
      c_clr = clr_err;
      c_din.msg_addr = job_msg_addr;
      c_din.out_addr = job_out_addr;
      for (int i = 0; i < 2; i++) begin
        c_done[i] = core_done[i];
        c_push[i] = job_valid && (mq[i].size() < DEPTH);
      end
      if (reset) started = 1;
    end
  end

  // core model: idle through the start cycle and cdly more, then busy for cblen cycles
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (cnever) begin
          core_done[k] = 1'b1;
        end else if (core_start[k]) begin
          chold[k] = crand ? $urandom_range(1, 3) : cdly;
          clow[k]  = crand ? $urandom_range(1, 12) : cblen;
          core_done[k] = 1'b1;
        end else if (chold[k] > 0) begin
          core_done[k] = 1'b1;
          chold[k]--;
        end else if (clow[k] > 0) begin
          core_done[k] = 1'b0;
          clow[k]--;
        end else begin
          core_done[k] = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [15:0] m, input logic [15:0] o);
    int t = 0;
    job_valid = 1'b1;
    job_msg_addr = m;
    job_out_addr = o;
    while (!job_ready[0] && t < 500) begin
      step(1);
      t++;
    end
    if (t >= 500) fail_bound("push_job");
    step(1);
    job_valid = 1'b0;
  endtask

  task automatic wait_cmp(input int n, input int budget);
    int t = 0;
    while (cmp_log[0].size() < n && t < budget) begin
      step(1);
      t++;
    end
    if (cmp_log[0].size() < n) fail_bound($sformatf("wait_cmp_%0d", n));
  endtask

  initial begin
    int t;
    int n;
    step(3);
    reset = 1'b0;
    step(2);

    // single job, 200-cycle core
    push_job(16'h0000, 16'h0100);
    wait_cmp(1, 400);
    chk("t1_starts", starts[0], 1);
    if (cmp_log[0].size() > 0) chk("t1_cmp_addr", cmp_log[0][0], 16'h0100);
    chk("t1_jobs_done", jobs_done[0], 1);
    chk("t1_model_jobs", mjobs[0], 1);
    chk("t1_err_to50", err[1], 1);
    chk("t1_nocmp_to50", cmp_log[1].size(), 0);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    step(2);

    // fill and order
    cblen = 30;
    for (int k = 0; k < 5; k++) push_job(16'h1000 + 16'(k), 16'h0010 + 16'(k));
    chk("t2_ready_low", job_ready[0], 0);
    chk("t2_fifo_count", dut0.u_fifo.count, 4);
    wait_cmp(6, 400);
    for (int k = 0; k < 5; k++)
      if (cmp_log[0].size() > 1 + k) chk($sformatf("t2_order%0d", k), cmp_log[0][1 + k], 16'h0010 + 16'(k));

    // push on the same edge as a pop with two queued
    cblen = 20;
    push_job(16'h2000, 16'h0020);
    push_job(16'h2100, 16'h0021);
    push_job(16'h2200, 16'h0022);
    t = 0;
    while (!cmp_valid[0] && t < 200) begin
      step(1);
      t++;
    end
    if (!cmp_valid[0]) fail_bound("t3_cmp");
    step(1);
    job_valid = 1'b1;
    job_msg_addr = 16'h2300;
    job_out_addr = 16'h0023;
    step(1);
    job_valid = 1'b0;
    chk("t3_start", core_start[0], 1);
    chk("t3_fifo_count", dut0.u_fifo.count, 2);
    chk("t3_model_count", mq[0].size(), 2);
    wait_cmp(10, 300);
    for (int k = 0; k < 4; k++)
      if (cmp_log[0].size() > 6 + k) chk($sformatf("t3_order%0d", k), cmp_log[0][6 + k], 16'h0020 + 16'(k));

    // jobs_done wrap
    cblen = 5;
    force dut0.jobs_done = 16'hFFFF;
    mjobs[0] = 16'hFFFF;
    step(1);
    release dut0.jobs_done;
    push_job(16'h3000, 16'h0030);
    wait_cmp(11, 100);
    chk("t4_wrap", jobs_done[0], 0);
    chk("t4_model_wrap", mjobs[0], 0);

    // timeout with a core that never drops done
    cnever = 1;
    push_job(16'h4000, 16'h0040);
    t = 0;
    while (!core_start[1] && t < 20) begin
      step(1);
      t++;
    end
    if (!core_start[1]) fail_bound("t5_start");
    step(50);
    chk("t5_err_before", err[1], 0);
    step(1);
    chk("t5_err_after", err[1], 1);
    push_job(16'h4100, 16'h0041);
    chk("t5_push_in_error", dut1.u_fifo.count, 1);
    t = 0;
    while (!err[0] && t < 1100) begin
      step(1);
      t++;
    end
    if (!err[0]) fail_bound("t5_err0");
    chk("t5_nocmp0", cmp_log[0].size(), 11);
    chk("t5_nocmp1", cmp_log[1].size(), 10);
    cnever = 0;
    cblen = 10;
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    wait_cmp(12, 100);
    if (cmp_log[0].size() > 11) chk("t5_restart0", cmp_log[0][11], 16'h0041);
    chk("t5_n1", cmp_log[1].size(), 11);
    if (cmp_log[1].size() > 10) chk("t5_restart1", cmp_log[1][10], 16'h0041);

    // randomized traffic
    crand = 1;
    for (int k = 0; k < 300; k++) begin
      job_valid = 1'($urandom_range(0, 1));
      job_msg_addr = 16'($urandom);
      job_out_addr = 16'($urandom);
      clr_err = ($urandom_range(0, 31) == 0);
      step(1);
    end
    job_valid = 1'b0;
    clr_err = 1'b0;
    step(120);
    crand = 0;

    // reset 20 cycles into WAIT_DONE with 2 jobs queued
    cdly = 1;
    cblen = 200;
    push_job(16'h7000, 16'h0070);
    push_job(16'h7100, 16'h0071);
    push_job(16'h7200, 16'h0072);
    t = 0;
    while (core_done[0] && t < 20) begin
      step(1);
      t++;
    end
    if (core_done[0]) fail_bound("t7_busy");
    step(21);
    chk("t7_queued", dut0.u_fifo.count, 2);
    n = cmp_log[0].size();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t7_job_ready", job_ready[0], 1);
    chk("t7_core_start", core_start[0], 0);
    chk("t7_cmp_valid", cmp_valid[0], 0);
    chk("t7_cmp_out_addr", cout[0], 0);
    chk("t7_core_msg", cma[0], 0);
    chk("t7_core_out", coa[0], 0);
    chk("t7_jobs_done", jobs_done[0], 0);
    chk("t7_err", err[0], 0);
    chk("t7_busy", busy[0], 0);
    chk("t7_timer", dut0.timer, 0);
    step(250);
    chk("t7_no_cmp", cmp_log[0].size(), n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
